// File: rtl/functions_stream_if.sv
// Sample stream into the measurement engine.
// Handshake: a sample transfers on a rising clk edge where sample_valid && sample_ready are both high.
// sample_ready does not depend on sample_valid. A valid sample presented while ready is low is dropped.
interface functions_stream_if #(
  parameter int DATA_W = 12
) ();
  logic [DATA_W-1:0] sample;
  logic              sample_valid;
  logic              sample_ready;

  modport master (output sample, output sample_valid, input sample_ready);
  modport slave  (input sample, input sample_valid, output sample_ready);
endinterface

// File: rtl/functions_stream.sv
// Streaming frame measurement engine: min/max/p-p/mean/mean-abs of (sample - GND) per frame.
// Readout refreshes on a free-running timer tick and can be frozen with hold.
module functions_stream #(
  parameter int DATA_W        = 12,
  parameter int SAMPLES       = 512,
  parameter int GND           = 2048,
  parameter int UPDATE_CYCLES = 100_000_000
) (
  input  logic                     clk,
  input  logic                     rst,
  functions_stream_if.slave        s_if,
  input  logic                     hold,
  output logic                     frame_done,
  output logic                     overrun,
  output logic signed [DATA_W:0]   vmin,
  output logic signed [DATA_W:0]   vmax,
  output logic        [DATA_W:0]   vpp,
  output logic signed [DATA_W:0]   vmean,
  output logic        [DATA_W:0]   vabs,
  output logic                     state_dbg
);
  localparam int LOG = $clog2(SAMPLES);
  localparam int SW  = DATA_W + 1 + LOG;
  localparam int AW  = DATA_W + LOG;
  localparam int TW  = (UPDATE_CYCLES > 1) ? $clog2(UPDATE_CYCLES) : 1;
  localparam logic [DATA_W:0] GND_C   = (DATA_W+1)'(GND);
  localparam logic [TW-1:0]   TICK_AT = TW'(UPDATE_CYCLES - 1);
  localparam logic [LOG-1:0]  LAST    = LOG'(SAMPLES - 1);

  typedef enum logic {ACCUM = 1'b0, CLOSE = 1'b1} state_t;

  state_t                  state;
  logic                    ready_q;
  logic [LOG-1:0]          count;
  logic signed [DATA_W:0]  min_q, max_q;
  logic signed [SW-1:0]    sum_d;
  logic [AW-1:0]           sum_abs;
  logic signed [DATA_W:0]  fmin, fmax, fmean;
  logic [DATA_W:0]         fpp, fabs;
  logic [TW-1:0]           timer;
  logic                    pending;

  logic signed [DATA_W:0]  d;
  logic [DATA_W:0]         d_neg;
  logic [DATA_W-1:0]       d_abs;
  logic signed [SW-1:0]    d_ext;
  logic [AW-1:0]           abs_ext;
  logic signed [SW-1:0]    mean_full;
  logic [AW-1:0]           abs_full;
  logic [DATA_W:0]         pp;
  logic                    accept;
  logic                    tick;

  // Offset to signed volts-relative code; |d| fits DATA_W bits even for d = -GND.
  assign d         = $signed({1'b0, s_if.sample} - GND_C);
  assign d_neg     = -d;
  assign d_abs     = d[DATA_W] ? d_neg[DATA_W-1:0] : d[DATA_W-1:0];
  assign d_ext     = $signed({{LOG{d[DATA_W]}}, d});
  assign abs_ext   = {{LOG{1'b0}}, d_abs};
  assign mean_full = sum_d >>> LOG;
  assign abs_full  = sum_abs >> LOG;
  assign pp        = $unsigned(max_q - min_q);
  assign accept    = s_if.sample_valid && ready_q;
  assign tick      = (timer == TICK_AT);

  assign s_if.sample_ready = ready_q;
  assign state_dbg         = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ACCUM;
      ready_q    <= 1'b1;
      count      <= '0;
      min_q      <= '0;
      max_q      <= '0;
      sum_d      <= '0;
      sum_abs    <= '0;
      fmin       <= '0;
      fmax       <= '0;
      fpp        <= '0;
      fmean      <= '0;
      fabs       <= '0;
      timer      <= '0;
      pending    <= 1'b0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
      vmin       <= '0;
      vmax       <= '0;
      vpp        <= '0;
      vmean      <= '0;
      vabs       <= '0;
    end else begin
      timer      <= tick ? '0 : timer + 1'b1;
      frame_done <= 1'b0;
      if (s_if.sample_valid && !ready_q) overrun <= 1'b1;

      case (state)
        ACCUM: begin
          if (accept) begin
            if (count == '0) begin
              min_q   <= d;
              max_q   <= d;
              sum_d   <= d_ext;
              sum_abs <= abs_ext;
            end else begin
              if (d < min_q) min_q <= d;
              if (d > max_q) max_q <= d;
              sum_d   <= sum_d + d_ext;
              sum_abs <= sum_abs + abs_ext;
            end
            count <= count + 1'b1;
            if (count == LAST) begin
              state   <= CLOSE;
              ready_q <= 1'b0;
            end
          end
        end
        CLOSE: begin
          fmin       <= min_q;
          fmax       <= max_q;
          fpp        <= pp;
          fmean      <= mean_full[DATA_W:0];
          fabs       <= {1'b0, abs_full[DATA_W-1:0]};
          frame_done <= 1'b1;
          count      <= '0;
          min_q      <= '0;
          max_q      <= '0;
          sum_d      <= '0;
          sum_abs    <= '0;
          state      <= ACCUM;
          ready_q    <= 1'b1;
        end
        default: begin
          state   <= ACCUM;
          ready_q <= 1'b1;
        end
      endcase

      // A frame closing on a tick edge is shown at the following tick.
      if (tick && pending && !hold) begin
        vmin  <= fmin;
        vmax  <= fmax;
        vpp   <= fpp;
        vmean <= fmean;
        vabs  <= fabs;
      end
      if (state == CLOSE) pending <= 1'b1;
      else if (tick && !hold) pending <= 1'b0;
    end
  end
endmodule

// File: tb/tb_functions_stream.sv
// Randomised scoreboard bench for functions_stream (SAMPLES=8, UPDATE_CYCLES=20).
module tb_functions_stream;
  localparam int DW   = 12;
  localparam int NS   = 8;
  localparam int GNDV = 2048;
  localparam int UC   = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic hold = 1'b0;
  logic frame_done, overrun, state_dbg;
  logic signed [DW:0] vmin, vmax, vmean;
  logic [DW:0] vpp, vabs;

  functions_stream_if #(.DATA_W(DW)) s_if ();

  functions_stream #(
    .DATA_W(DW), .SAMPLES(NS), .GND(GNDV), .UPDATE_CYCLES(UC)
  ) dut (
    .clk(clk), .rst(rst), .s_if(s_if), .hold(hold),
    .frame_done(frame_done), .overrun(overrun),
    .vmin(vmin), .vmax(vmax), .vpp(vpp), .vmean(vmean), .vabs(vabs),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    int                 due;
    logic signed [DW:0] mn;
    logic signed [DW:0] mx;
    logic        [DW:0] pp;
    logic signed [DW:0] mean;
    logic        [DW:0] ab;
  } frame_t;

  frame_t exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp, input int cyc);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s act=%0d exp=%0d cyc=%0d", name, act, exp, cyc);
    end
  endtask

  // Reference frame statistics from plain integer arithmetic.
  function automatic frame_t mk_frame(input int due, input int v[NS]);
    frame_t f;
    int mn, mx, s, sa, q;
    mn = v[0]; mx = v[0]; s = 0; sa = 0;
    for (int i = 0; i < NS; i++) begin
      if (v[i] < mn) mn = v[i];
      if (v[i] > mx) mx = v[i];
      s  += v[i];
      sa += (v[i] < 0) ? -v[i] : v[i];
    end
    q = s / NS;
    if ((s % NS != 0) && (s < 0)) q = q - 1;
    f.due  = due;
    f.mn   = (DW+1)'(mn);
    f.mx   = (DW+1)'(mx);
    f.pp   = (DW+1)'(mx - mn);
    f.mean = (DW+1)'(q);
    f.ab   = (DW+1)'(sa / NS);
    return f;
  endfunction

  // Monitor: tracks the reference model per edge and compares every output.
  initial begin
    int cyc, m_cnt, m_tmr;
    bit m_closing, m_ovr, m_pend, tick, in_rst, in_v, in_h, fd_exp;
    logic [DW-1:0] in_s;
    int fr[NS];
    frame_t m_latest, m_ro, f;
    cyc = 0; m_cnt = 0; m_tmr = 0;
    m_closing = 0; m_ovr = 0; m_pend = 0;
    m_latest = '0; m_ro = '0;
    forever begin
      @(posedge clk);
      in_rst = rst; in_v = s_if.sample_valid; in_s = s_if.sample; in_h = hold;
      #1;
      fd_exp = 0;
      if (in_rst) begin
        cyc = 0; m_cnt = 0; m_tmr = 0;
        m_closing = 0; m_ovr = 0; m_pend = 0;
        m_latest = '0; m_ro = '0;
        exp_q.delete();
      end else begin
        cyc++;
        tick  = (m_tmr == UC - 1);
        m_tmr = tick ? 0 : m_tmr + 1;
        if (tick && m_pend && !in_h) begin
          m_ro   = m_latest;
          m_pend = 0;
        end
        if (m_closing) begin
          m_closing = 0;
          if (in_v) m_ovr = 1;
        end else if (in_v) begin
          fr[m_cnt] = int'(in_s) - GNDV;
          m_cnt++;
          if (m_cnt == NS) begin
            exp_q.push_back(mk_frame(cyc + 1, fr));
            m_cnt = 0;
            m_closing = 1;
          end
        end
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
          f = exp_q.pop_front();
          m_latest = f;
          m_pend = 1;
          fd_exp = 1;
        end
      end
      chk("frame_done", int'(frame_done), int'(fd_exp), cyc);
      chk("sample_ready", int'(s_if.sample_ready), int'(!m_closing), cyc);
      chk("state_dbg", int'(state_dbg), int'(m_closing), cyc);
      chk("overrun", int'(overrun), int'(m_ovr), cyc);
      chk("vmin", int'(vmin), int'(m_ro.mn), cyc);
      chk("vmax", int'(vmax), int'(m_ro.mx), cyc);
      chk("vpp", int'(vpp), int'(m_ro.pp), cyc);
      chk("vmean", int'(vmean), int'(m_ro.mean), cyc);
      chk("vabs", int'(vabs), int'(m_ro.ab), cyc);
    end
  end

  // Handshake-respecting driver: holds valid low while ready is low.
  task automatic send_g(input logic [DW-1:0] s);
    int tries;
    tries = 0;
    @(negedge clk);
    while (!s_if.sample_ready && tries < 16) begin
      s_if.sample_valid = 1'b0;
      tries++;
      @(negedge clk);
    end
    checks++;
    if (tries >= 16) begin
      errors++;
      $display("FAIL ready_timeout act=0 exp=1");
    end
    s_if.sample = s;
    s_if.sample_valid = 1'b1;
  endtask

  task automatic send_u(input logic [DW-1:0] s);
    @(negedge clk);
    s_if.sample = s;
    s_if.sample_valid = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      s_if.sample_valid = 1'b0;
    end
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b1;
    s_if.sample_valid = 1'b0;
    repeat (n) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    s_if.sample = '0;
    s_if.sample_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NS; i++) send_g(12'd2048);
    idle(25);
    for (int i = 0; i < NS; i++) send_g((i % 2) ? 12'd3048 : 12'd1048);
    idle(25);
    for (int i = 0; i < NS; i++) send_g(12'd2047);
    idle(25);
    send_g(12'd2047);
    for (int i = 1; i < NS; i++) send_g(12'd2048);
    idle(25);

    for (int i = 0; i < 4 * NS; i++) send_g(DW'($urandom_range(0, 4095)));
    idle(25);

    @(negedge clk);
    hold = 1'b1;
    for (int i = 0; i < 2 * NS; i++) send_g(DW'($urandom_range(0, 4095)));
    idle(45);
    hold = 1'b0;
    idle(25);

    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      else send_g(DW'($urandom_range(0, 4095)));
      if ($urandom_range(0, 15) == 0) hold = ~hold;
    end
    hold = 1'b0;
    idle(25);

    for (int i = 0; i < NS + 1; i++) send_u(12'd2048);
    idle(25);

    for (int i = 0; i < 5; i++) send_u(12'd4000);
    do_reset(2);
    for (int i = 0; i < NS; i++) send_g(12'd2100);
    idle(25);

    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 4) == 0) idle(1);
      else send_u(DW'($urandom_range(0, 4095)));
    end
    idle(25);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
